// File: rtl/mac_tx_retry_ctrl_pkg.sv
// Shared types and defaults for the CSMA/CD transmit retry controller.
// Build option: MAC_TX_RETRY_STATS_EN adds collision/abort statistics.
package mac_tx_retry_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IFG,
    ST_SEND,
    ST_JAM,
    ST_BACKOFF,
    ST_DRAIN
  } state_t;

  localparam int DEF_SLOT_TIME     = 128;
  localparam int DEF_IFG_CYCLES    = 24;
  localparam int DEF_JAM_CYCLES    = 8;
  localparam int DEF_MAX_ATTEMPTS  = 16;
  localparam int DEF_BACKOFF_LIMIT = 10;

  localparam logic [9:0] LFSR_SEED = 10'h001;

  function automatic logic [9:0] backoff_mask(
    input logic [4:0] k
  );
    logic [10:0] m;
    m = (11'd1 << k) - 11'd1;
    return m[9:0];
  endfunction

endpackage

// File: rtl/mac_tx_retry_ctrl_lfsr10.sv
// 10-bit Fibonacci LFSR (taps 10,7) feeding the backoff draw.
// Build option: none (see MAC_TX_RETRY_STATS_EN in the top).
module mac_tx_retry_ctrl_lfsr10 (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] seed,
  output logic [9:0] q
);

  logic fb;

  assign fb = q[9] ^ q[6];

  // an all-zero state would lock up, so it falls back to the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= seed;
    end else if (enable) begin
      if (q == '0) q <= seed;
      else         q <= {q[8:0], fb};
    end
  end

endmodule

// File: rtl/mac_tx_retry_ctrl.sv
// Half-duplex Ethernet CSMA/CD retry sequencer around a replay buffer.
// Build option: MAC_TX_RETRY_STATS_EN adds stat_collisions/stat_aborts.
module mac_tx_retry_ctrl
  import mac_tx_retry_ctrl_pkg::*;
#(
  parameter int SLOT_TIME     = DEF_SLOT_TIME,
  parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
  parameter int JAM_CYCLES    = DEF_JAM_CYCLES,
  parameter int MAX_ATTEMPTS  = DEF_MAX_ATTEMPTS,
  parameter int BACKOFF_LIMIT = DEF_BACKOFF_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        buf_valid,
  input  logic        buf_ready,
  input  logic        buf_last,
  input  logic        replayable,
  input  logic        collision,
  output logic        replay,
  output logic        done,
  output logic        tx_enable,
  output logic        jam,
  output logic        drop,
  output logic        tx_ok,
  output logic        tx_abort,
  output logic        late_col
`ifdef MAC_TX_RETRY_STATS_EN
  ,
  output logic [15:0] stat_collisions,
  output logic [15:0] stat_aborts
`endif
);

  localparam int CMAX =
    (IFG_CYCLES > JAM_CYCLES) ?
    IFG_CYCLES : JAM_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW =
    (SLOT_TIME > 1) ? $clog2(SLOT_TIME) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   slot_cnt;
  logic [9:0]      slots;
  logic [4:0]      attempts;
  logic            late_r;
  logic            ifg_to_send;
  logic [9:0]      lfsr_q;

  logic            hs;
  logic            last_hs;
  logic            col;
  logic [4:0]      att_inc;
  logic            att_max;
  logic [4:0]      k;
  logic [9:0]      r;

  mac_tx_retry_ctrl_lfsr10 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (1'b1),
    .seed   (LFSR_SEED),
    .q      (lfsr_q)
  );

  assign hs      = buf_valid & buf_ready;
  assign last_hs = hs & buf_last;
  assign col     = (state == ST_SEND) & collision;
  assign att_inc = attempts + 5'd1;
  assign att_max = (att_inc == 5'(MAX_ATTEMPTS));

  assign k = (attempts > 5'(BACKOFF_LIMIT)) ?
             5'(BACKOFF_LIMIT) : attempts;
  assign r = lfsr_q & backoff_mask(k);

  assign tx_enable = (state == ST_SEND);
  assign jam       = (state == ST_JAM);
  assign drop      = (state == ST_DRAIN);

  // collision outranks a simultaneous last handshake
  assign tx_ok    = tx_enable & last_hs & ~collision;
  assign replay   = col & replayable & ~att_max;
  assign done     = tx_ok
                  | (col & (~replayable | att_max));
  assign tx_abort = drop & last_hs;
  assign late_col = tx_abort & late_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      slot_cnt    <= '0;
      slots       <= '0;
      attempts    <= '0;
      late_r      <= 1'b0;
      ifg_to_send <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (buf_valid) begin
            state       <= ST_IFG;
            cnt         <= CW'(IFG_CYCLES - 1);
            ifg_to_send <= 1'b1;
          end
        end
        ST_IFG: begin
          if (cnt == '0) begin
            state <= ifg_to_send ? ST_SEND : ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SEND: begin
          if (collision) begin
            if (replayable) begin
              attempts <= att_inc;
              if (att_max) begin
                state  <= ST_DRAIN;
                late_r <= 1'b0;
              end else begin
                state <= ST_JAM;
                cnt   <= CW'(JAM_CYCLES - 1);
              end
            end else begin
              state  <= ST_DRAIN;
              late_r <= 1'b1;
            end
          end else if (last_hs) begin
            attempts    <= '0;
            state       <= ST_IFG;
            cnt         <= CW'(IFG_CYCLES - 1);
            ifg_to_send <= 1'b0;
          end
        end
        ST_JAM: begin
          if (cnt == '0) begin
            if (r == '0) begin
              state       <= ST_IFG;
              cnt         <= CW'(IFG_CYCLES - 1);
              ifg_to_send <= 1'b1;
            end else begin
              state    <= ST_BACKOFF;
              slots    <= r;
              slot_cnt <= SW'(SLOT_TIME - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (slot_cnt == '0) begin
            if (slots == 10'd1) begin
              state       <= ST_IFG;
              cnt         <= CW'(IFG_CYCLES - 1);
              ifg_to_send <= 1'b1;
            end else begin
              slots    <= slots - 10'd1;
              slot_cnt <= SW'(SLOT_TIME - 1);
            end
          end else begin
            slot_cnt <= slot_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_hs) begin
            attempts <= '0;
            late_r   <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAC_TX_RETRY_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_collisions <= '0;
      stat_aborts     <= '0;
    end else begin
      if (col && stat_collisions != 16'hFFFF)
        stat_collisions <= stat_collisions + 16'd1;
      if (tx_abort && stat_aborts != 16'hFFFF)
        stat_aborts <= stat_aborts + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mac_tx_retry_ctrl.md
Name: mac_tx_retry_ctrl

Overview:
- Sequences a replay buffer sitting in the half-duplex Ethernet transmit path, implementing CSMA/CD retry.
- Snoops the buffer's master handshake and watches PHY collision indications.
- Drives replay/done into the buffer and gates/jams/drops in the downstream transmitter.
- Implements inter-frame gap, jam, truncated binary exponential backoff, 16-attempt abort and late-collision drop.

Parameters:
- SLOT_TIME, 128, clock cycles per backoff slot (512 bit times / 4 bits per cycle).
- IFG_CYCLES, 24, idle cycles required between frames and before every retry.
- JAM_CYCLES, 8, cycles jam asserted after a collision.
- MAX_ATTEMPTS, 16, transmit attempts before abort.
- BACKOFF_LIMIT, 10, cap on backoff exponent.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- buf_valid  in  1  replay buffer m_axis valid (snooped)
- buf_ready  in  1  downstream ready (snooped)
- buf_last  in  1  replay buffer m_axis last (snooped)
- replayable  in  1  from buffer; replay legal when high
- collision  in  1  PHY collision, level, synchronous to clk
- replay  out  1  one-cycle pulse to buffer
- done  out  1  one-cycle pulse to buffer
- tx_enable  out  1  downstream may transmit buffer data
- jam  out  1  downstream sends jam pattern
- drop  out  1  downstream must accept and discard data
- tx_ok  out  1  pulse, frame sent
- tx_abort  out  1  pulse, frame dropped (excess or late collision)
- late_col  out  1  qualifies tx_abort: late collision cause

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-high (rst). All outputs 0 at reset; state IDLE; attempts=0; LFSR=10'h001.
- hs = buf_valid && buf_ready.
- States: IDLE, IFG, SEND, JAM, BACKOFF, DRAIN.
- IDLE: when buf_valid -> IFG, load counter IFG_CYCLES-1.
- IFG: all gates 0. Counter hits 0 -> SEND next cycle. Collision ignored.
- SEND: tx_enable=1.
  - hs && buf_last && !collision -> done and tx_ok pulse same cycle; attempts=0; -> IFG. The next frame is not started until buf_valid in IDLE; IFG is then re-run.
  - collision && replayable: replay pulse this cycle; attempts+=1.
    - If new attempts==MAX_ATTEMPTS: replay suppressed; done pulse; -> DRAIN, with tx_abort on drain completion, late_col=0.
    - Else -> JAM.
  - collision && !replayable: done pulse; -> DRAIN with late_col=1.
  - Collision takes priority over a simultaneous last handshake.
- JAM: jam=1, tx_enable=0, JAM_CYCLES cycles.
  - On exit: k=min(attempts,BACKOFF_LIMIT); r=lfsr[9:0] & ((1<<k)-1).
  - r==0 -> IFG; else -> BACKOFF.
- BACKOFF: waits exactly r*SLOT_TIME cycles (slot counter plus slot-count register), then -> IFG. Collision ignored.
- DRAIN: drop=1. On hs && buf_last: tx_abort pulse; late_col held 1 that cycle if cause was late; attempts=0; -> IDLE.
- Output rules:
  - replay never asserted when replayable is 0.
  - replay and done never in the same cycle.
  - done issued exactly once per frame.
- LFSR: 10-bit Fibonacci, taps 10,7, advances every cycle, never all-zero.
- Counters: attempts 5 bits; slot counter $clog2(SLOT_TIME) bits; slot-count register 10 bits.
- Reset mid-frame returns to IDLE. The buffer is reset by the same rst.

Optional Feature:
- MAC_TX_RETRY_STATS_EN defined: adds outputs stat_collisions[15:0] (+1 per collision in SEND) and stat_aborts[15:0] (+1 per tx_abort). Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared header: state encodings, default SLOT_TIME/IFG/JAM values, MAX_ATTEMPTS, BACKOFF_LIMIT.
- One sub-module: lfsr10 (enable, seed, 10-bit state out).

Test Plan:
- 60-beat frame, no collision:
  - tx_enable after 24 IFG cycles.
  - done and tx_ok on last hs.
  - replay never asserted.
- Collision at beat 10, replayable=1:
  - replay pulse; jam high 8 cycles.
  - Backoff 0 or 128 cycles (attempt 1), then IFG 24, then frame restarts.
- Force LFSR seed; collision every attempt:
  - 16th collision gives done, no replay, drop until last, then tx_abort with late_col=0.
  - Backoff lengths equal r*128 with mask width min(n,10).
- Collision at beat 60 with replayable=0: done pulse, drop=1 to end of frame, tx_abort with late_col=1.
- Collision in the same cycle as last hs with replayable=1: replay taken, no tx_ok.
- rst asserted during BACKOFF: all outputs 0 immediately; next frame begins with IFG; attempts=0.
